// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and address helper for the data-memory stage
package dmem_pkg;

    localparam int DMEM_DEPTH_LOG2 = 8;
    localparam int DMEM_LATENCY    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Byte address to word index; bits above the memory depth are masked so accesses wrap.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int depth_log2);
        return (byte_addr >> 2) & ((32'd1 << depth_log2) - 32'd1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with synchronous write and registered read data
module dmem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data-memory controller with stall/done handshake; optional DMEM_MISALIGN_CHECK_EN
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
    parameter int LATENCY    = DMEM_LATENCY,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] md,
    output logic              stall,
    output logic              done,
    output logic              err
);

    dmem_state_t           state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [DATA_W-1:0]     cap_wdata;
    logic                  cap_write;
    logic                  cap_both;
    logic                  request;
    logic                  fire;
    logic                  misalign;
    logic                  we;
    logic                  re;

    assign request = mem_read | mem_write;
    assign fire    = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [1:0] cap_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_lo <= 2'b00;
        end else if (state == IDLE && request) begin
            cap_lo <= addr[1:0];
        end
    end

    assign misalign = (cap_lo != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign we = fire && cap_write && !misalign;
    assign re = fire && !cap_write && !misalign;

    // The request cycle already stalls; gating with rst_n keeps stall low while held in reset.
    assign stall = rst_n && (((state == IDLE) && request) || (state == BUSY));
    assign done  = (state == DONE);
    assign err   = (state == DONE) && (cap_both || misalign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            cap_both  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        cap_idx   <= DEPTH_LOG2'(word_index(addr, DEPTH_LOG2));
                        cap_wdata <= wdata;
                        cap_write <= mem_write;
                        cap_both  <= mem_read & mem_write;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // A request still high here belongs to the completing instruction.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .re    (re),
        .idx   (cap_idx),
        .wdata (cap_wdata),
        .rdata (md)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] md;
    logic        stall;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    int          n_stall;
    int          n_done;
    int          n_err;
    int          n_cyc;
    logic [31:0] md_done;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .md        (md),
        .stall     (stall),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drives a request just after a rising edge and follows it until done (bounded).
    // Inputs stay asserted on return so the request is held through the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit churn);
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        n_stall = 0;
        n_done  = 0;
        n_err   = 0;
        n_cyc   = -1;
        md_done = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (done) begin
                n_done++;
                if (err) n_err++;
                n_cyc   = i;
                md_done = md;
                break;
            end
            if (churn && i == 1) begin
                addr  = 32'h0000_0080;
                wdata = 32'hBAD0_BAD0;
            end
        end
        if (n_done == 0) $display("FAIL access_timeout: got=no done expected=done within 20 cycles");
    endtask

    task automatic go_idle(input int cycles, output int dones);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    int extra;

    initial begin
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_md", md, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;

        access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
        check("wr40_stalls", n_stall, 3);
        check("wr40_latency", n_cyc, 3);
        check("wr40_dones", n_done, 1);
        check("wr40_err", n_err, 0);
        check("wr40_md_untouched", md_done, 32'h0);
        go_idle(2, extra);

        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        check("rd40_stalls", n_stall, 3);
        check("rd40_latency", n_cyc, 3);
        check("rd40_md", md_done, 32'h1234_5678);
        check("rd40_err", n_err, 0);
        go_idle(2, extra);

        access(1'b0, 1'b1, 32'h80, 32'h0BAD_CAFE, 1'b0);
        go_idle(1, extra);
        access(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b1);
        go_idle(1, extra);
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        check("churn_rd40", md_done, 32'hCAFE_F00D);
        go_idle(1, extra);
        access(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
        check("churn_rd80", md_done, 32'h0BAD_CAFE);

        // Back-to-back: the write is held through DONE, the load follows in the next IDLE.
        access(1'b0, 1'b1, 32'h44, 32'h55AA_55AA, 1'b0);
        check("b2b_wr_dones", n_done, 1);
        check("b2b_wr_md_holds", md_done, 32'h0BAD_CAFE);
        access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
        check("b2b_rd_dones", n_done, 1);
        check("b2b_rd_latency", n_cyc, 3);
        check("b2b_rd_md", md_done, 32'h55AA_55AA);
        go_idle(6, extra);
        check("b2b_no_dup_done", extra, 0);

        access(1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0);
        go_idle(1, extra);
        access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
        check("wrap_rd0", md_done, 32'hA5A5_A5A5);
        go_idle(1, extra);

        access(1'b1, 1'b1, 32'h8, 32'h0000_0077, 1'b0);
        check("both_err", n_err, 1);
        check("both_dones", n_done, 1);
        check("both_md_holds", md_done, 32'hA5A5_A5A5);
        go_idle(1, extra);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        check("both_wrote", md_done, 32'h0000_0077);
        check("both_rd_err", n_err, 0);
        go_idle(1, extra);

        access(1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_md_holds", md_done, 32'h0000_0077);
        check("mis_err", n_err, 1);
`else
        check("mis_md_word40", md_done, 32'hCAFE_F00D);
        check("mis_err", n_err, 0);
`endif
        check("mis_latency", n_cyc, 3);
        go_idle(1, extra);

        // Reset mid-BUSY of a write to 0x10.
        access(1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0);
        go_idle(1, extra);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("rst_pre_md", md_done, 32'h1111_1111);
        go_idle(1, extra);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        addr      = 32'h10;
        wdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_md", md, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("rst_stall_held", {31'b0, stall}, 32'd0);
        mem_write = 1'b0;
        rst_n = 1'b1;
        go_idle(5, extra);
        check("rst_no_done", extra, 0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("rst_mem_kept", md_done, 32'h1111_1111);
        go_idle(2, extra);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes the ALU result (address), read-data-2 (store data), memRead and memWrite.
- Returns load data on `md`, and holds the datapath with a stall signal for the duration of a multi-cycle memory access.
- Owns a word-organised synchronous RAM plus a request/completion state machine.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words).
- LATENCY, 2, stall cycles per access; legal range 1..15.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  load request from control unit.
- mem_write  in  1  store request from control unit.
- addr  in  32  byte address (ALU result).
- wdata  in  DATA_W  store data (read data 2).
- md  out  DATA_W  load data to writeback mux.
- stall  out  1  freeze PC and register-file write while high.
- done  out  1  one-cycle pulse: access complete.
- err  out  1  one-cycle pulse with done: request fault.

Behaviour:
- Reset (async, rst_n low): state=IDLE, md=0, done=0, err=0, wait counter=0. Memory contents are not cleared. stall=0 while in reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read|mem_write, capture addr, wdata and the op type; load the counter with LATENCY-1; go to BUSY.
  - stall is combinational: stall=1 in the request cycle itself.
  - No request: stay in IDLE, stall=0.
- BUSY:
  - stall=1. Counter decrements each cycle.
  - At counter==0, perform the access on the clock edge into DONE:
    - Write: mem[word] <= captured wdata.
    - Read: md <= mem[word].
  - Inputs are ignored after capture. Changes on the inputs during BUSY have no effect.
- DONE:
  - stall=0 and done=1 for exactly one cycle; the datapath advances at this edge.
  - Always returns to IDLE. A request still asserted in DONE is the completing instruction's and is not re-accepted.
  - The next instruction's request is sampled in IDLE.
- Latency: from the request cycle to the done pulse is LATENCY+1 cycles.
  - LATENCY=1: IDLE -> BUSY(1 cycle) -> DONE.
  - Total stalled cycles = LATENCY+1 including the request cycle.
- Word index = captured addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
- md holds the last read value until the next read completes. Writes do not change md.
- mem_read and mem_write both high in IDLE: treated as a write; err=1 together with done.
- Reset during BUSY: access aborted, memory unchanged, md=0, no done pulse.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- Defined: a captured addr[1:0]!=0 suppresses the access. Memory and md are unchanged; err=1 with done. Timing is identical to a normal access.
- Undefined: addr[1:0] is ignored and the access goes to the containing word.

Decomposition:
- Shared package dmem_pkg holds:
  - State enum dmem_state_t {IDLE, BUSY, DONE}.
  - Default constants DMEM_DEPTH_LOG2=8 and DMEM_LATENCY=2.
  - Word-index slicing helper.
- One sub-module, dmem_array: single-port RAM with a synchronous write enable and a registered read into md, instantiated by dmem_ctrl.
- The FSM and counter stay in dmem_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY after a write of 0xDEADBEEF to addr 0x10 -> md=0, stall=0, done never pulses; a later read of 0x10 returns the prior contents.
- Write then read: store 0x12345678 at 0x40, then load 0x40 with LATENCY=2 -> stall high 3 cycles each, done one cycle, md=0x12345678.
- Input churn: change addr to 0x80 and wdata during BUSY of a write to 0x40 -> only word 0x40 is written; 0x80 is unchanged.
- Back-to-back: request held through DONE, then a new load in the next IDLE cycle -> exactly one done per access, no duplicate access.
- Wrap: with DEPTH_LOG2=8, write 0xA5A5A5A5 to 0x400, then read 0x000 -> md=0xA5A5A5A5. Read+write together -> write performed, err=1 with done.
- Misalign (macro defined): load 0x42 -> md unchanged, err=1 with done. Macro undefined: load 0x42 returns the word at 0x40, err=0.
